count_mod10: RTL and testbench

COUNT_MOD10 -- requirements
Module: count_mod10

---
 rtl/count_mod10_if.sv | 13 +
 rtl/count_mod10.sv | 35 +++
 tb/tb_count_mod10.sv | 94 +++++++++
 3 files changed

// File: rtl/count_mod10_if.sv
// Bench-side bundle of the count_mod10 signals; the DUT binds to these by name.
interface count_if (
    input logic clock
);
    logic       reset;
    logic       mode;
    logic       load;
    logic [3:0] data_in;
    logic [3:0] data_out;

    modport dut (input clock, reset, mode, load, data_in, output data_out);
    modport tb  (input clock, data_out, output reset, mode, load, data_in);
endinterface

// File: rtl/count_mod10.sv
// Modulo-10 up/down counter with synchronous parallel load.
// Priority per edge is reset, then load, then count.
module count_mod10 (
    input  logic       clock,
    input  logic       reset,
    input  logic       mode,
    input  logic       load,
    input  logic [3:0] data_in,
    output logic [3:0] data_out
);
    logic [3:0] count_q;
    logic [3:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            // Out-of-range load values clamp to zero so the count stays in 0..9.
            count_d = (data_in > 4'd9) ? 4'd0 : data_in;
        end else if (mode) begin
            count_d = (count_q == 4'd9) ? 4'd0 : count_q + 4'd1;
        end else begin
            count_d = (count_q == 4'd0) ? 4'd9 : count_q - 4'd1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            count_q <= 4'd0;
        end else begin
            count_q <= count_d;
        end
    end

    assign data_out = count_q;
endmodule

// File: tb/tb_count_mod10.sv
// Directed and randomized checks of count_mod10 against an arithmetic reference model.
module tb_count_mod10;
    logic clock = 1'b0;
    always #5 clock = ~clock;

    count_if cif (.clock(clock));

    count_mod10 dut (
        .clock   (cif.clock),
        .reset   (cif.reset),
        .mode    (cif.mode),
        .load    (cif.load),
        .data_in (cif.data_in),
        .data_out(cif.data_out)
    );

    int n_chk  = 0;
    int n_fail = 0;
    int ref_q  = 0;

    task automatic chk(input string tag, input logic [3:0] got, input logic [3:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Drive one edge worth of inputs, advance the model, then check after the edge.
    task automatic step(input logic r, input logic m, input logic l, input logic [3:0] d);
        cif.reset   = r;
        cif.mode    = m;
        cif.load    = l;
        cif.data_in = d;
        @(posedge clock);
        if (r)      ref_q = 0;
        else if (l) ref_q = (int'(d) <= 9) ? int'(d) : 0;
        else if (m) ref_q = (ref_q + 1) % 10;
        else        ref_q = (ref_q + 9) % 10;
        #1;
        chk("model", cif.data_out, 4'(ref_q));
        if (cif.data_out > 4'd9) chk("range", cif.data_out, 4'(ref_q % 10));
    endtask

    int up_tbl[12] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 0, 1, 2};
    int dn_tbl[4]  = '{1, 0, 9, 8};

    initial begin
        cif.reset = 1'b1; cif.mode = 1'b1; cif.load = 1'b0; cif.data_in = 4'd0;

        step(1'b1, 1'b1, 1'b0, 4'd0);
        chk("reset", cif.data_out, 4'd0);

        for (int i = 0; i < 12; i++) begin
            step(1'b0, 1'b1, 1'b0, 4'd0);
            chk("count_up", cif.data_out, 4'(up_tbl[i]));
        end

        step(1'b0, 1'b1, 1'b1, 4'd2);
        chk("load2", cif.data_out, 4'd2);
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b0, 1'b0, 4'd0);
            chk("count_dn", cif.data_out, 4'(dn_tbl[i]));
        end

        step(1'b0, 1'b1, 1'b1, 4'd13);
        chk("load13_clamp", cif.data_out, 4'd0);
        step(1'b0, 1'b0, 1'b1, 4'd9);
        chk("load9", cif.data_out, 4'd9);
        step(1'b0, 1'b1, 1'b1, 4'd4);
        step(1'b0, 1'b0, 1'b1, 4'd4);
        chk("load_hold", cif.data_out, 4'd4);

        step(1'b1, 1'b1, 1'b1, 4'd5);
        chk("reset_over_load", cif.data_out, 4'd0);

        for (int i = 0; i < 7; i++) step(1'b0, 1'b1, 1'b0, 4'd0);
        chk("at7", cif.data_out, 4'd7);
        step(1'b0, 1'b0, 1'b0, 4'd0);
        chk("mode_flip", cif.data_out, 4'd6);

        step(1'b1, 1'b1, 1'b0, 4'd0);
        step(1'b0, 1'b0, 1'b0, 4'd0);
        chk("resume_down", cif.data_out, 4'd9);

        for (int i = 0; i < 500; i++) begin
            step(($urandom_range(31) == 0), 1'($urandom), ($urandom_range(7) == 0),
                 4'($urandom_range(15)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
